// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the buffered 8N1 UART transmitter.
//   tx_state_t : transmit FSM states
//   DATA_BITS, STOP_BITS, FRAME_BITS, IDLE_LEVEL : 8N1 framing constants
//   clog2()    : counter/pointer width helper (never returns less than 1)
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int   DATA_BITS  = 8;
  localparam int   STOP_BITS  = 1;
  localparam int   FRAME_BITS = 10;
  localparam logic IDLE_LEVEL = 1'b1;

  // Bits needed to hold the values 0..value-1; at least 1 so that a
  // degenerate range still yields a legal vector width.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous byte FIFO feeding the UART serializer.
//   clk, reset    : system clock, synchronous active-high reset
//   push, wdata   : write request and data; ignored while full
//   pop, rdata    : read request; rdata shows the head entry (fall-through)
//   full          : registered, high when DEPTH entries are held
//   empty         : no entries held
//   nonempty_next : entry count after the coming edge is non-zero
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             nonempty_next
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             push_ok, pop_ok;

  // A write is refused whenever the registered full flag is set, even if a
  // pop frees a slot on the same edge.
  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & (count_q != '0);

  // NOTE: every signal driven here gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointers wrap modulo DEPTH by overflow.
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CNT_W'(DEPTH));
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end

  assign rdata         = mem[rd_ptr_q];
  assign full          = full_q;
  assign empty         = (count_q == '0);
  assign nonempty_next = (count_d != '0);

endmodule

// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
// Buffered 8N1 UART transmitter. Bytes written on tx_enable are queued in a
// FIFO and sent LSB-first; queued frames follow each other with no idle gap.
//   clk, reset : system clock, synchronous active-high reset
//   txdata     : byte to send, captured when tx_enable is high
//   tx_enable  : one-cycle write strobe
//   tx         : registered serial output, idle high
//   tx_full    : FIFO full, writes are dropped while high
//   tx_busy    : registered; frame in progress or bytes still queued
//   overrun    : one-cycle pulse after a write that hit a full FIFO
// ---------------------------------------------------------------------------
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 32,
  parameter int DEPTH        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] txdata,
  input  logic       tx_enable,
  output logic       tx,
  output logic       tx_full,
  output logic       tx_busy,
  output logic       overrun
);

  localparam int                BAUD_W    = clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam int                IDX_W     = clog2(DATA_BITS);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;
  logic                 bit_done;

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_nonempty_next;
  logic [DATA_BITS-1:0] fifo_rdata;

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .push          (tx_enable),
    .wdata         (txdata),
    .pop           (fifo_pop),
    .rdata         (fifo_rdata),
    .full          (fifo_full),
    .empty         (fifo_empty),
    .nonempty_next (fifo_nonempty_next)
  );

  // tx_d always carries the level of the cycle that follows the edge, so the
  // serial line changes together with the state and has no input-to-output
  // combinational path.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;
    bit_done  = (baud_q == BAUD_LAST);

    if (state_q != IDLE) baud_d = bit_done ? '0 : baud_q + BAUD_W'(1);

    unique case (state_q)
      IDLE: begin
        tx_d = IDLE_LEVEL;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          baud_d   = '0;
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == IDX_LAST) begin
            state_d = STOP;
            tx_d    = IDLE_LEVEL;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            tx_d    = IDLE_LEVEL;
            state_d = IDLE;
          end
        end
      end
      default: begin
        tx_d    = IDLE_LEVEL;
        state_d = IDLE;
      end
    endcase
  end

  assign overrun_d = tx_enable & fifo_full;
  // Built from next-cycle values so the registered flag lines up with the
  // registered state and FIFO count.
  assign busy_d    = (state_d != IDLE) | fifo_nonempty_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign tx      = tx_q;
  assign tx_full = fifo_full;
  assign tx_busy = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_buffered
// Drives two transmitters (4 and 2 clocks per bit, DEPTH 4). The stimulus
// pushes each expected 10-bit frame (start, data LSB-first, stop) into a
// queue; a negedge monitor detects start bits, pops the queue and compares
// every serial cycle of the frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_buffered;

  localparam int CPB_A = 4;
  localparam int CPB_B = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, tx_a, full_a, busy_a, ovr_a;
  logic       rst_b, en_b, tx_b, full_b, busy_b, ovr_b;
  logic [7:0] data_a, data_b;

  uart_tx_buffered #(.CLKS_PER_BIT(CPB_A), .DEPTH(DEPTH)) dut_a (
    .clk(clk), .reset(rst_a), .txdata(data_a), .tx_enable(en_a),
    .tx(tx_a), .tx_full(full_a), .tx_busy(busy_a), .overrun(ovr_a));

  uart_tx_buffered #(.CLKS_PER_BIT(CPB_B), .DEPTH(DEPTH)) dut_b (
    .clk(clk), .reset(rst_b), .txdata(data_b), .tx_enable(en_b),
    .tx(tx_b), .tx_full(full_b), .tx_busy(busy_b), .overrun(ovr_b));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard: expected frames, bit 0 = start bit, bit 9 = stop bit.
  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];
  int         start_a[$];
  int         start_b[$];
  bit         in_frame[2];
  int         pos[2];
  int         bad[2];
  logic [9:0] cur[2];
  bit         abort_a = 1'b0;

  task automatic mon_step(input int id, input logic txv, input int cpb);
    int slot;
    if (id == 0 && abort_a) begin
      in_frame[0] = 1'b0;
      abort_a     = 1'b0;
    end
    if (!in_frame[id] && txv === 1'b0) begin
      in_frame[id] = 1'b1;
      pos[id]      = 0;
      bad[id]      = 0;
      cur[id]      = '1;
      if (id == 0) begin
        start_a.push_back(cyc);
        check("frame_expected_a", 32'(exp_a.size() != 0), 1);
        if (exp_a.size() != 0) cur[0] = exp_a.pop_front();
      end else begin
        start_b.push_back(cyc);
        check("frame_expected_b", 32'(exp_b.size() != 0), 1);
        if (exp_b.size() != 0) cur[1] = exp_b.pop_front();
      end
    end
    if (in_frame[id]) begin
      slot = pos[id] / cpb;
      if (txv !== cur[id][slot]) bad[id]++;
      pos[id]++;
      if (pos[id] == 10 * cpb) begin
        in_frame[id] = 1'b0;
        if (id == 0) check("frame_bits_a", 32'(bad[0]), 0);
        else         check("frame_bits_b", 32'(bad[1]), 0);
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, tx_a, CPB_A);
    mon_step(1, tx_b, CPB_B);
  end

  // Stimulus runs just after each falling edge, after the monitor has sampled.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_start(input int id, input int budget, output int s);
    int n;
    n = 0;
    while (((id == 0) ? start_a.size() : start_b.size()) == 0 && n < budget) begin
      step();
      n++;
    end
    s = -1;
    if (id == 0 && start_a.size() != 0) s = start_a[0];
    if (id == 1 && start_b.size() != 0) s = start_b[0];
  endtask

  task automatic wait_drain(input int id, input int budget, input string name);
    int n;
    bit pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < budget) begin
      pending = (id == 0) ? (exp_a.size() != 0 || in_frame[0])
                          : (exp_b.size() != 0 || in_frame[1]);
      if (pending) begin
        step();
        n++;
      end
    end
    check(name, 32'(pending), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         s, wr, lows, gaps, gap;
    logic [5:0] full_exp;
    logic [5:0] ovr_exp;
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
    data_a = '0; data_b = '0;
    repeat (3) step();

    // Reset state of both instances
    check("reset_tx_a",   32'(tx_a),   1);
    check("reset_full_a", 32'(full_a), 0);
    check("reset_busy_a", 32'(busy_a), 0);
    check("reset_ovr_a",  32'(ovr_a),  0);
    check("reset_tx_b",   32'(tx_b),   1);
    check("reset_busy_b", 32'(busy_b), 0);
    rst_a = 1'b0; rst_b = 1'b0;
    step();

    // Single byte 0xA5: start one cycle after the write, 40-cycle frame
    start_a.delete();
    exp_a.push_back({1'b1, 8'hA5, 1'b0});
    data_a = 8'hA5; en_a = 1'b1; step(); en_a = 1'b0;
    wr = cyc;
    check("busy_after_write", 32'(busy_a), 1);
    wait_start(0, 10, s);
    check("latency_a5", 32'(s), 32'(wr + 1));
    wait_drain(0, 60, "drain_a5");
    check("busy_in_stop", 32'(busy_a), 1);
    step();
    check("busy_after_frame", 32'(busy_a), 0);
    check("tx_idle_after_frame", 32'(tx_a), 1);
    repeat (3) step();

    // 0x00 then 0xFF on consecutive cycles: frames abut exactly
    start_a.delete();
    exp_a.push_back({1'b1, 8'h00, 1'b0});
    exp_a.push_back({1'b1, 8'hFF, 1'b0});
    data_a = 8'h00; en_a = 1'b1; step();
    data_a = 8'hFF; step(); en_a = 1'b0;
    wait_drain(0, 120, "drain_pair");
    check("pair_frames", 32'(start_a.size()), 2);
    gap = (start_a.size() >= 2) ? start_a[1] - start_a[0] : -1;
    check("pair_gap", 32'(gap), 40);
    repeat (3) step();

    // Six back-to-back writes: five accepted, the sixth overruns
    start_a.delete();
    full_exp = 6'b110000;
    ovr_exp  = 6'b100000;
    for (int i = 0; i < 5; i++) exp_a.push_back({1'b1, 8'(8'h11 + i), 1'b0});
    for (int i = 0; i < 6; i++) begin
      data_a = 8'(8'h11 + i); en_a = 1'b1;
      step();
      check("burst_full", 32'(full_a), 32'(full_exp[i]));
      check("burst_ovr",  32'(ovr_a),  32'(ovr_exp[i]));
    end
    en_a = 1'b0;
    step();
    check("ovr_one_cycle", 32'(ovr_a), 0);
    wait_drain(0, 260, "drain_burst");
    check("burst_frames", 32'(start_a.size()), 5);
    repeat (3) step();

    // Reset in the middle of DATA aborts the frame and drops queued bytes
    start_a.delete();
    exp_a.push_back({1'b1, 8'h3C, 1'b0});
    data_a = 8'h3C; en_a = 1'b1; step();
    data_a = 8'h99; step(); en_a = 1'b0;
    wait_start(0, 10, s);
    repeat (12) step();
    check("busy_before_reset", 32'(busy_a), 1);
    abort_a = 1'b1; rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    check("abort_tx",   32'(tx_a),   1);
    check("abort_busy", 32'(busy_a), 0);
    check("abort_full", 32'(full_a), 0);
    lows = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (tx_a !== 1'b1) lows++;
    end
    check("quiet_after_reset", 32'(lows), 0);
    check("frames_after_reset", 32'(start_a.size()), 1);

    // Thirteen bytes, each written once a slot frees: pointer wrap-around
    start_a.delete();
    for (int i = 1; i <= 13; i++) begin
      int n;
      n = 0;
      while (full_a !== 1'b0 && n < 200) begin
        step();
        n++;
      end
      check("slot_free", 32'(full_a), 0);
      exp_a.push_back({1'b1, 8'(i), 1'b0});
      data_a = 8'(i); en_a = 1'b1; step(); en_a = 1'b0;
      check("wrap_no_ovr", 32'(ovr_a), 0);
    end
    wait_drain(0, 700, "drain_wrap");
    check("wrap_frames", 32'(start_a.size()), 13);
    gaps = 0;
    for (int i = 1; i < start_a.size(); i++) begin
      if (start_a[i] - start_a[i-1] != 40) gaps++;
    end
    check("wrap_back_to_back", 32'(gaps), 0);
    repeat (3) step();

    // Two clocks per bit: 0x80 gives a 20-cycle frame
    start_b.delete();
    exp_b.push_back({1'b1, 8'h80, 1'b0});
    data_b = 8'h80; en_b = 1'b1; step(); en_b = 1'b0;
    wr = cyc;
    wait_start(1, 10, s);
    check("latency_b", 32'(s), 32'(wr + 1));
    wait_drain(1, 40, "drain_b");
    check("busy_b_in_stop", 32'(busy_b), 1);
    step();
    check("busy_b_after", 32'(busy_b), 0);
    check("tx_b_idle", 32'(tx_b), 1);
    check("full_b_idle", 32'(full_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
Buffered 8N1 UART transmitter: accepts parallel bytes on a strobe handshake, queues them in a small FIFO and serializes them LSB-first on tx.
Drives the FTDI-facing tx pin for board-level designs that send host-bound traffic. Uses the same txdata/tx_enable byte interface as the uart core.
Frames are sent back-to-back with no idle gap while the FIFO holds data.

Parameters:
CLKS_PER_BIT, 32, clk cycles per serial bit (32 = clk32 oversample rate); legal range 2..1023
DEPTH, 4, FIFO depth in bytes; power of 2, 2..16

Ports:
clk  in  1  single system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
txdata  in  8  byte to transmit
tx_enable  in  1  one-cycle write strobe for txdata
tx  out  1  serial output, idle high
tx_full  out  1  FIFO full; writes are dropped while high
tx_busy  out  1  high while a frame is on the wire or the FIFO is non-empty
overrun  out  1  one-cycle pulse when tx_enable arrives while tx_full is high

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: tx=1, tx_full=0, tx_busy=0, overrun=0. FIFO pointers and count = 0. FSM = IDLE, bit and baud counters = 0.
- Reset mid-frame aborts immediately: tx=1 after the reset edge, queued bytes are discarded, no partial stop bit is sent.
- Write: on an edge with tx_enable=1 and tx_full=0, txdata is pushed.
- Dropped write: on an edge with tx_enable=1 and tx_full=1, the byte is dropped and overrun=1 for the following cycle.
- tx_full is registered from count==DEPTH. A write is rejected while full even if a pop occurs on the same edge.
- Simultaneous push and pop when not full: count is unchanged and both complete.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty, pop into shift register, clear baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the last cycle, if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Latency: a byte written at edge E0 into an empty FIFO with the FSM in IDLE drives tx low after edge E1, one cycle later.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- tx is a registered output; no combinational path from any input to tx.
- tx_busy = (state!=IDLE) | (count!=0), registered.

Decomposition:
- Shared package uart_pkg holds:
  - tx_state_t enum {IDLE, START, DATA, STOP}
  - constants DATA_BITS=8, STOP_BITS=1, FRAME_BITS=10, IDLE_LEVEL=1'b1
  - the clog2 helper for counter widths
- One sub-module, uart_tx_fifo: synchronous FIFO with push/pop/full/empty and DEPTH parameter.
- The top-level block holds the FSM, baud counter, shift register and overrun logic.

Test Plan:
- CLKS_PER_BIT=4, write 0xA5 -> tx, 4 cycles per bit, starting one cycle after write: 0,1,0,1,0,0,1,0,1,1. Frame is 40 cycles; tx_busy drops after the stop bit.
- Write 0x00 then 0xFF on consecutive cycles -> two frames of 40 cycles each. Stop bit of frame 1 is immediately followed by start bit of frame 2, no idle cycles.
- DEPTH=4, write 6 bytes on 6 consecutive cycles while idle. The first byte pops one cycle after its write, so 5 bytes are accepted. tx_full=1 after the 5th write; the 6th is dropped with overrun pulsed for exactly 1 cycle. The 5 accepted bytes are transmitted in order.
- Assert reset for 1 cycle in the middle of the DATA state -> tx=1 on the next edge and stays high. tx_busy=0, tx_full=0, and no further frames are sent.
- Write 13 bytes (0x01..0x0D), each written as a slot frees. Covers FIFO pointer wrap-around at DEPTH=4: serial output order matches write order with no duplication or loss.
- CLKS_PER_BIT=2 boundary: write 0x80 -> tx sequence 0, then 0 x7, then 1 (data), then 1 (stop), 2 cycles per bit. Frame is 20 cycles.
